deca_vip_led_pwm: RTL and testbench
===================================

Name: deca_vip_led_pwm

Overview:
Downstream stage of the 8-bit LED PIO. It consumes the PIO's registered LED pattern and drives the board LED pins with a global PWM brightness and an optional blink. Software configures it through its own Avalon-MM slave with four word registers. It is zero-wait-state and uses the same single clock domain as the PIO.

Parameters:
PRESCALE, 4, clocks per PWM tick (>=1); PWM frame = 256*PRESCALE clocks
ACTIVE_LOW, 1, 1 = LED pins lit when 0 (board LEDs); 0 = lit when 1
DUTY_RST, 8'h80, reset value of DUTY register
BLINK_RST, 16'd0, reset value of BLINK register

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  Avalon register select
chipselect  in  1  Avalon select
write_n  in  1  Avalon write strobe, active-low
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, combinational, zero-extended
led_pattern  in  8  LED on/off pattern from PIO out_port (same clock)
led_out  out  8  LED pin drive, registered

Behaviour:
- Register map. Write when chipselect & ~write_n.
  - 0 CTRL: [0] enable, [1] blink_en. Reset 0.
  - 1 DUTY: [7:0]. Reset DUTY_RST.
  - 2 BLINK: [15:0] blink half-period in PWM frames. Reset BLINK_RST.
  - 3 STATUS: read-only, [0] blink_phase, [15:8] pat_act. Writes ignored.
  - Read of an unused bit returns 0. readdata is a pure address mux with no latency.
- Pattern path:
  - led_pattern is registered into pat_in (1 clk).
  - pat_act <= pat_in only at frame_end, giving a glitch-free update.
  - pat_in and pat_act reset to 0.
- Prescaler:
  - pre_cnt counts 0..PRESCALE-1. tick = (pre_cnt == PRESCALE-1). Wraps to 0.
  - pwm_cnt (8b) increments on tick and wraps 255->0.
  - frame_end = tick & (pwm_cnt == 255).
  - Counters free-run regardless of enable.
- Blink:
  - blk_cnt (16b) increments on frame_end.
  - When blink_en and blk_cnt >= max(BLINK,1)-1 at frame_end: blk_cnt <= 0 and blink_phase toggles.
  - When blink_en = 0: blk_cnt held at 0 and blink_phase = 1.
  - Write to BLINK: blk_cnt <= 0 and blink_phase <= 1 in the same cycle. This overrides the frame_end update.
- Lit term per bit i:
  - lit[i] = enable & pat_act[i] & pwm_on & blink_phase.
  - pwm_on = (DUTY == 255) | (pwm_cnt < DUTY). DUTY 0 = never on; DUTY 255 = always on.
- Output: led_out <= lit ^ {8{ACTIVE_LOW}}, registered with 1 clk latency from the lit term.
  - Reset value: all LEDs off (8'hFF when ACTIVE_LOW=1, else 8'h00).
- Register write timing:
  - A CTRL/DUTY write takes effect on lit the cycle after the write. led_out follows 1 clk later.
  - Clearing enable mid-frame turns all LEDs off within 2 clks. Counters are unaffected.
- Reset mid-operation: all registers and counters return to reset values asynchronously. led_out goes off immediately.
- Simultaneous events:
  - A CTRL write and a frame_end in the same cycle: the blink logic uses the old blink_en.
  - A pattern change in the same cycle as a frame_end latches the value already in pat_in (old pattern).

Test Plan:
- Reset check: assert reset_n=0 mid-run -> led_out=8'hFF, readdata at addr1=0x80, addr0=0, addr2=0.
- Full on: write CTRL=1, DUTY=255, led_pattern=8'hA5 -> after next frame_end (<=1024+2 clks) led_out=8'h5A constant, STATUS[15:8]=0xA5.
- PWM duty: CTRL=1, DUTY=64, pattern=8'h01 -> bit0 low for exactly 64*4=256 clks per 1024-clk frame; bits7:1 stay 1; DUTY=0 -> bit0 always 1.
- Glitch-free update: change led_pattern 8'h01->8'h80 mid-frame -> led_out unchanged until frame_end, then switches within 2 clks.
- Blink: CTRL=3, DUTY=255, BLINK=2, pattern=8'hFF -> led_out alternates 8'h00 for 2048 clks then 8'hFF for 2048 clks; STATUS[0] toggles at each boundary; BLINK=0 toggles every frame.
- Disable/blink restart: write CTRL=0 mid-frame -> led_out=8'hFF within 2 clks. Write BLINK during the off phase -> STATUS[0]=1 the next cycle.

Source files
------------

// File: rtl/deca_vip_led_pwm.sv
// deca_vip_led_pwm: PWM brightness and blink stage between the LED PIO and the board LED pins.
// Four-word zero-wait-state Avalon-MM slave: CTRL, DUTY, BLINK, STATUS (read-only).
module deca_vip_led_pwm #(
   parameter int unsigned  PRESCALE   = 4,
   parameter bit           ACTIVE_LOW = 1'b1,
   parameter logic [7:0]   DUTY_RST   = 8'h80,
   parameter logic [15:0]  BLINK_RST  = 16'd0
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   input  logic [7:0]  led_pattern,
   output logic [7:0]  led_out
);

   localparam int unsigned      PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(PRESCALE - 1);
   localparam logic [7:0]       LED_OFF = {8{ACTIVE_LOW}};

   logic             r_enable;
   logic             r_blink_en;
   logic [7:0]       r_duty;
   logic [15:0]      r_blink;
   logic [7:0]       r_pat_in;
   logic [7:0]       r_pat_act;
   logic [PRE_W-1:0] r_pre_cnt;
   logic [7:0]       r_pwm_cnt;
   logic [15:0]      r_blk_cnt;
   logic             r_blink_phase;
   logic [7:0]       r_led_out;

   logic             w_wr;
   logic             w_wr_ctrl;
   logic             w_wr_duty;
   logic             w_wr_blink;
   logic             w_tick;
   logic             w_frame_end;
   logic [15:0]      w_blink_lim;
   logic             w_blink_wrap;
   logic             w_pwm_on;
   logic [7:0]       w_lit;
   logic [31:0]      w_rdata;
   logic             w_unused;

   assign w_wr       = chipselect & ~write_n;
   assign w_wr_ctrl  = w_wr & (address == 2'd0);
   assign w_wr_duty  = w_wr & (address == 2'd1);
   assign w_wr_blink = w_wr & (address == 2'd2);

   assign w_tick      = (r_pre_cnt == PRE_MAX);
   assign w_frame_end = w_tick & (r_pwm_cnt == 8'hFF);

   // BLINK of 0 behaves like 1: toggle every frame
   assign w_blink_lim  = (r_blink == 16'd0) ? 16'd0 : (r_blink - 16'd1);
   assign w_blink_wrap = (r_blk_cnt >= w_blink_lim);

   assign w_pwm_on = (r_duty == 8'hFF) | (r_pwm_cnt < r_duty);
   assign w_lit    = {8{r_enable & w_pwm_on & r_blink_phase}} & r_pat_act;

   assign w_unused = &{1'b0, writedata[31:16]};

   // Software-writable configuration registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_enable   <= 1'b0;
         r_blink_en <= 1'b0;
         r_duty     <= DUTY_RST;
         r_blink    <= BLINK_RST;
      end else begin
         if (w_wr_ctrl) begin
            r_enable   <= writedata[0];
            r_blink_en <= writedata[1];
         end
         if (w_wr_duty) begin
            r_duty <= writedata[7:0];
         end
         if (w_wr_blink) begin
            r_blink <= writedata[15:0];
         end
      end
   end

   // Pattern capture; the active pattern only changes on a frame boundary
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pat_in  <= '0;
         r_pat_act <= '0;
      end else begin
         r_pat_in <= led_pattern;
         if (w_frame_end) begin
            r_pat_act <= r_pat_in;
         end
      end
   end

   // Free-running prescaler and PWM ramp
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_pre_cnt <= '0;
         r_pwm_cnt <= '0;
      end else begin
         r_pre_cnt <= w_tick ? '0 : (r_pre_cnt + 1'b1);
         if (w_tick) begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
         end
      end
   end

   // Blink frame counter and phase; a BLINK write restarts the lit phase
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_blk_cnt     <= '0;
         r_blink_phase <= 1'b1;
      end else if (w_wr_blink || !r_blink_en) begin
         r_blk_cnt     <= '0;
         r_blink_phase <= 1'b1;
      end else if (w_frame_end) begin
         if (w_blink_wrap) begin
            r_blk_cnt     <= '0;
            r_blink_phase <= ~r_blink_phase;
         end else begin
            r_blk_cnt <= r_blk_cnt + 16'd1;
         end
      end
   end

   // Registered pin drive with polarity applied
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_led_out <= LED_OFF;
      end else begin
         r_led_out <= w_lit ^ LED_OFF;
      end
   end

   // Zero-latency read mux, unused bits read as 0
   always_comb begin
      w_rdata = '0;
      case (address)
         2'd0: w_rdata[1:0]  = {r_blink_en, r_enable};
         2'd1: w_rdata[7:0]  = r_duty;
         2'd2: w_rdata[15:0] = r_blink;
         2'd3: begin
            w_rdata[0]    = r_blink_phase;
            w_rdata[15:8] = r_pat_act;
         end
         default: w_rdata = '0;
      endcase
   end

   assign readdata = w_rdata;
   assign led_out  = r_led_out;

endmodule

// File: tb/tb_deca_vip_led_pwm.sv
// Directed bench for deca_vip_led_pwm with a queue scoreboard and negedge monitor.
// cyc counts rising edges since reset release; the DUT counters are aligned to it,
// so frame_end lands on the edge where cyc becomes a multiple of 1024.
module tb_deca_vip_led_pwm;

   logic        clk;
   logic        reset_n;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  led_pattern;
   logic [7:0]  led_out;

   typedef struct {
      bit          is_rd;
      logic [31:0] exp;
      string       name;
   } chk_t;

   chk_t        q[$];
   int unsigned n_cmp;
   int unsigned n_bad;
   int unsigned cyc;

   deca_vip_led_pwm #(
      .PRESCALE   (4),
      .ACTIVE_LOW (1'b1),
      .DUTY_RST   (8'h80),
      .BLINK_RST  (16'd0)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .address     (address),
      .chipselect  (chipselect),
      .write_n     (write_n),
      .writedata   (writedata),
      .readdata    (readdata),
      .led_pattern (led_pattern),
      .led_out     (led_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) cyc <= 0;
      else          cyc <= cyc + 1;
   end

   // Monitor: consume every expectation queued during this cycle
   initial begin
      chk_t e;
      logic [31:0] act;
      n_cmp = 0;
      n_bad = 0;
      forever begin
         @(negedge clk);
         while (q.size() > 0) begin
            e   = q.pop_front();
            act = e.is_rd ? readdata : {24'd0, led_out};
            n_cmp++;
            if (act !== e.exp) begin
               n_bad++;
               $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic goto_cyc(input int unsigned c);
      while (cyc < c) step();
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      step();
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic chk_led(input logic [7:0] exp, input string name);
      chk_t e;
      e.is_rd = 1'b0;
      e.exp   = {24'd0, exp};
      e.name  = $sformatf("%s@%0d", name, cyc);
      q.push_back(e);
   endtask

   task automatic chk_rd(input logic [1:0] a, input logic [31:0] exp, input string name);
      chk_t e;
      address = a;
      e.is_rd = 1'b1;
      e.exp   = exp;
      e.name  = $sformatf("%s@%0d", name, cyc);
      q.push_back(e);
   endtask

   initial begin
      int unsigned pwm;
      reset_n     = 1'b0;
      address     = 2'd0;
      chipselect  = 1'b0;
      write_n     = 1'b1;
      writedata   = '0;
      led_pattern = 8'h00;

      // Reset state
      step();
      chk_led(8'hFF, "rst_led");
      chk_rd(2'd1, 32'h80, "rst_duty");
      step();
      chk_rd(2'd0, 32'h0, "rst_ctrl");
      step();
      chk_rd(2'd2, 32'h0, "rst_blink");
      step();
      chk_rd(2'd3, 32'h1, "rst_status");
      step();
      reset_n = 1'b1;

      // Full on: pattern becomes active at the frame_end on edge 1024
      led_pattern = 8'hA5;
      wr(2'd0, 32'h1);
      wr(2'd1, 32'hFF);
      goto_cyc(1023); chk_led(8'hFF, "full_pre");
      goto_cyc(1024); chk_led(8'hFF, "full_edge");
      goto_cyc(1025); chk_led(8'h5A, "full_on");
      goto_cyc(1030); chk_led(8'h5A, "full_hold"); chk_rd(2'd3, 32'hA501, "full_status");
      goto_cyc(1031); chk_rd(2'd1, 32'hFF, "duty_rb");
      goto_cyc(1032); chk_rd(2'd0, 32'h1, "ctrl_rb");

      // PWM duty 64 on bit0 across one full frame (256 low cycles of 1024)
      goto_cyc(1040);
      led_pattern = 8'h01;
      wr(2'd1, 32'd64);
      for (int unsigned m = 2049; m <= 3072; m++) begin
         goto_cyc(m);
         pwm = ((m - 1) / 4) % 256;
         chk_led((pwm < 64) ? 8'hFE : 8'hFF, "duty64");
      end
      wr(2'd1, 32'd0);
      for (int unsigned m = 3074; m <= 4097; m++) begin
         goto_cyc(m);
         chk_led(8'hFF, "duty0");
      end

      // Glitch-free pattern update
      wr(2'd1, 32'hFF);
      for (int unsigned m = 4099; m <= 5120; m++) begin
         goto_cyc(m);
         chk_led(8'hFE, "glitch_hold");
         if (m == 4300) led_pattern = 8'h80;
      end
      for (int unsigned m = 5121; m <= 5130; m++) begin
         goto_cyc(m);
         chk_led(8'h7F, "glitch_new");
      end

      // Pattern change on the frame_end edge: old pat_in is latched
      goto_cyc(6143); led_pattern = 8'h3C;
      for (int unsigned m = 6145; m <= 6150; m++) begin
         goto_cyc(m);
         chk_led(8'h7F, "fe_old_pat");
      end
      goto_cyc(7168); chk_led(8'h7F, "fe_pre");
      goto_cyc(7169); chk_led(8'hC3, "fe_new_pat");

      // Blink with BLINK=2
      goto_cyc(7170);
      led_pattern = 8'hFF;
      wr(2'd0, 32'h3);
      wr(2'd2, 32'd2);
      chk_rd(2'd2, 32'd2, "blink_rb");
      goto_cyc(9215);  chk_rd(2'd3, 32'hFF01, "blk_st1");
      goto_cyc(9216);  chk_led(8'h00, "blk_on1");  chk_rd(2'd3, 32'hFF00, "blk_st0");
      goto_cyc(9217);  chk_led(8'hFF, "blk_off1");
      goto_cyc(11263); chk_led(8'hFF, "blk_off2"); chk_rd(2'd3, 32'hFF00, "blk_st0b");
      goto_cyc(11264); chk_led(8'hFF, "blk_off3"); chk_rd(2'd3, 32'hFF01, "blk_st1b");
      goto_cyc(11265); chk_led(8'h00, "blk_on2");
      goto_cyc(13312); chk_led(8'h00, "blk_on3");
      goto_cyc(13313); chk_led(8'hFF, "blk_off4");

      // BLINK=0 toggles every frame
      wr(2'd2, 32'd0);
      goto_cyc(13315); chk_led(8'h00, "b0_restart");
      goto_cyc(14335); chk_rd(2'd3, 32'hFF01, "b0_st1");
      goto_cyc(14336); chk_led(8'h00, "b0_on");  chk_rd(2'd3, 32'hFF00, "b0_st0");
      goto_cyc(14337); chk_led(8'hFF, "b0_off");
      goto_cyc(15360); chk_led(8'hFF, "b0_off2");
      goto_cyc(15361); chk_led(8'h00, "b0_on2");

      // BLINK write during the off phase restarts the lit phase
      goto_cyc(16500); chk_led(8'hFF, "rst_blk_off");
      wr(2'd2, 32'd5);
      chk_led(8'hFF, "rst_blk_lag");
      chk_rd(2'd3, 32'hFF01, "rst_blk_st");
      goto_cyc(16502); chk_led(8'h00, "rst_blk_on");

      // Disable mid-frame
      goto_cyc(16600);
      wr(2'd0, 32'h0);
      chk_led(8'h00, "dis_lag");
      goto_cyc(16602); chk_led(8'hFF, "dis_off"); chk_rd(2'd0, 32'h0, "dis_ctrl");
      goto_cyc(16603); chk_led(8'hFF, "dis_off2"); chk_rd(2'd3, 32'hFF01, "dis_phase");
      goto_cyc(16610);
      wr(2'd0, 32'h1);
      goto_cyc(16612); chk_led(8'h00, "reen_on");

      // Asynchronous reset mid-operation
      goto_cyc(16700);
      reset_n = 1'b0;
      chk_led(8'hFF, "mid_rst_led");
      chk_rd(2'd1, 32'h80, "mid_rst_duty");
      step();
      chk_rd(2'd0, 32'h0, "mid_rst_ctrl");
      step();
      chk_rd(2'd2, 32'h0, "mid_rst_blink");
      step();
      chk_rd(2'd3, 32'h1, "mid_rst_status");
      step();
      @(negedge clk);
      #1;
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending, expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
